// File: rtl/frame_scheduler.sv
// Frame-level sequencer: clear, gated triangle render, drain to frame-end marker,
// then a vblank-aligned buffer swap. Single clock domain, synchronous active-low reset.
module frame_scheduler #(
  parameter int unsigned DRAIN_TIMEOUT = 1048576,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             frame_start_valid,
  output logic             frame_start_ready,
  input  logic             tri_s_valid,
  output logic             tri_s_ready,
  input  logic             tri_s_last,
  output logic             tri_m_valid,
  input  logic             tri_m_ready,
  input  logic             px_valid,
  input  logic             px_ready,
  input  logic             px_last,
  output logic             clear_start,
  input  logic             clear_done,
  input  logic             vblank,
  output logic             swap,
  output logic             frame_done,
  output logic             busy,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] tri_count,
  output logic             err_timeout
);

  localparam int unsigned TO_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(DRAIN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RENDER,
    S_DRAIN,
    S_WAIT_VBL,
    S_SWAP
  } state_t;

  state_t           state_q, state_d;
  logic             clear_start_q, clear_start_d;
  logic [CNT_W-1:0] tri_cnt_q, tri_cnt_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             px_seen_q, px_seen_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             err_q, err_d;

  logic gate;
  logic fs_hs;
  logic tri_hs;
  logic px_hs;

  assign gate   = (state_q == S_RENDER);
  assign fs_hs  = frame_start_valid & (state_q == S_IDLE);
  assign tri_hs = tri_s_valid & tri_m_ready & gate;
  assign px_hs  = px_valid & px_ready & px_last;

  always_comb begin
    state_d       = state_q;
    clear_start_d = 1'b0;
    tri_cnt_d     = tri_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    px_seen_d     = px_seen_q;
    to_cnt_d      = '0;
    err_d         = err_q;
    case (state_q)
      S_IDLE: begin
        if (fs_hs) begin
          state_d       = S_CLEAR;
          clear_start_d = 1'b1;
          tri_cnt_d     = '0;
          px_seen_d     = 1'b0;
        end
      end
      S_CLEAR: begin
        if (clear_done) state_d = S_RENDER;
      end
      S_RENDER: begin
        if (px_hs) px_seen_d = 1'b1;
        if (tri_hs) begin
          if (tri_cnt_q != '1) tri_cnt_d = tri_cnt_q + CNT_W'(1);
          if (tri_s_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // A marker arriving on the timeout cycle itself wins over the timeout.
        if (px_seen_q || px_hs) begin
          px_seen_d = 1'b1;
          state_d   = S_WAIT_VBL;
        end else if (to_cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_WAIT_VBL;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_WAIT_VBL: begin
        if (vblank) state_d = S_SWAP;
      end
      S_SWAP: begin
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      clear_start_q <= 1'b0;
      tri_cnt_q     <= '0;
      frame_cnt_q   <= '0;
      px_seen_q     <= 1'b0;
      to_cnt_q      <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      clear_start_q <= clear_start_d;
      tri_cnt_q     <= tri_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      px_seen_q     <= px_seen_d;
      to_cnt_q      <= to_cnt_d;
      err_q         <= err_d;
    end
  end

  assign frame_start_ready = (state_q == S_IDLE);
  assign tri_s_ready       = tri_m_ready & gate;
  assign tri_m_valid       = tri_s_valid & gate;
  assign clear_start       = clear_start_q;
  assign swap              = (state_q == S_SWAP);
  assign frame_done        = (state_q == S_SWAP);
  assign busy              = (state_q != S_IDLE);
  assign frame_count       = frame_cnt_q;
  assign tri_count         = tri_cnt_q;
  assign err_timeout       = err_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Scoreboard bench for frame_scheduler: stimulus queues expected per-frame results,
// a monitor checks them on every swap pulse. A narrow-counter instance shares all inputs.
module tb_frame_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn, frame_start_valid, tri_s_valid, tri_s_last, tri_m_ready;
  logic px_valid, px_ready, px_last, clear_done, vblank;

  logic        frame_start_ready, tri_s_ready, tri_m_valid, clear_start;
  logic        swap, frame_done, busy, err_timeout;
  logic [15:0] frame_count, tri_count;

  logic        frame_start_ready_n, tri_s_ready_n, tri_m_valid_n, clear_start_n;
  logic        swap_n, frame_done_n, busy_n, err_timeout_n;
  logic [1:0]  frame_count_n, tri_count_n;

  frame_scheduler #(.DRAIN_TIMEOUT(64), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn),
    .frame_start_valid(frame_start_valid), .frame_start_ready(frame_start_ready),
    .tri_s_valid(tri_s_valid), .tri_s_ready(tri_s_ready), .tri_s_last(tri_s_last),
    .tri_m_valid(tri_m_valid), .tri_m_ready(tri_m_ready),
    .px_valid(px_valid), .px_ready(px_ready), .px_last(px_last),
    .clear_start(clear_start), .clear_done(clear_done), .vblank(vblank),
    .swap(swap), .frame_done(frame_done), .busy(busy),
    .frame_count(frame_count), .tri_count(tri_count), .err_timeout(err_timeout)
  );

  frame_scheduler #(.DRAIN_TIMEOUT(64), .CNT_W(2)) dut_n (
    .clk(clk), .rstn(rstn),
    .frame_start_valid(frame_start_valid), .frame_start_ready(frame_start_ready_n),
    .tri_s_valid(tri_s_valid), .tri_s_ready(tri_s_ready_n), .tri_s_last(tri_s_last),
    .tri_m_valid(tri_m_valid_n), .tri_m_ready(tri_m_ready),
    .px_valid(px_valid), .px_ready(px_ready), .px_last(px_last),
    .clear_start(clear_start_n), .clear_done(clear_done), .vblank(vblank),
    .swap(swap_n), .frame_done(frame_done_n), .busy(busy_n),
    .frame_count(frame_count_n), .tri_count(tri_count_n), .err_timeout(err_timeout_n)
  );

  typedef struct {
    int tc;
    bit err;
    int fc;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_clr    = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (clear_start === 1'b1) n_clr <= n_clr + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Swap monitor: every swap pulse must match the oldest queued frame result.
  initial begin
    forever begin
      @(negedge clk);
      if (swap === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("unexpected_swap", 1, 0);
        end else begin
          mon_e = sbq.pop_front();
          chk("frame_done", frame_done, 1);
          chk("narrow_swap", swap_n, 1);
          chk("narrow_frame_done", frame_done_n, 1);
          chk("tri_count", tri_count, mon_e.tc);
          chk("tri_count_sat", tri_count_n, (mon_e.tc > 3) ? 3 : mon_e.tc);
          chk("err_timeout", err_timeout, mon_e.err);
          chk("narrow_err_timeout", err_timeout_n, mon_e.err);
          chk("frame_count_pre", frame_count, mon_e.fc);
          if (mon_e.cyc >= 0) chk("swap_cycle", cyc, mon_e.cyc);
          @(negedge clk);
          chk("swap_width", swap, 0);
          chk("frame_count_post", frame_count, (mon_e.fc + 1) & 16'hFFFF);
          chk("frame_count_wrap", frame_count_n, (mon_e.fc + 1) % 4);
        end
      end else if (frame_done !== 1'b0) begin
        chk("frame_done_without_swap", frame_done, 0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic start_frame();
    frame_start_valid = 1'b1;
    for (int i = 0; i < 200 && frame_start_ready !== 1'b1; i++) tick();
    chk("start_ready", frame_start_ready, 1);
    tick();
    frame_start_valid = 1'b0;
    chk("clear_start_first", clear_start, 1);
    chk("narrow_clear_start", clear_start_n, 1);
    chk("clear_busy", busy, 1);
    chk("clear_not_ready", frame_start_ready, 0);
    tick();
    chk("clear_start_once", clear_start, 0);
  endtask

  task automatic clear_pulse();
    clear_done = 1'b1;
    tick();
    clear_done = 1'b0;
  endtask

  task automatic send_tri(input logic last);
    tri_s_valid = 1'b1;
    tri_s_last  = last;
    tri_m_ready = 1'b1;
    #1;
    chk("tri_handshake_ready", tri_s_ready, 1);
    tick();
    tri_s_valid = 1'b0;
    tri_s_last  = 1'b0;
  endtask

  task automatic px_pulse();
    px_valid = 1'b1; px_ready = 1'b1; px_last = 1'b1;
    tick();
    px_valid = 1'b0; px_ready = 1'b0; px_last = 1'b0;
  endtask

  task automatic wait_swap(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (swap === 1'b1) begin
        tick();
        return;
      end
      tick();
    end
    chk("swap_wait_expired", 0, 1);
  endtask

  initial begin
    int n;
    bit px_sent;
    rstn = 1'b0; frame_start_valid = 1'b0; tri_s_valid = 1'b0; tri_s_last = 1'b0;
    tri_m_ready = 1'b0; px_valid = 1'b0; px_ready = 1'b0; px_last = 1'b0;
    clear_done = 1'b0; vblank = 1'b1;
    repeat (3) tick();
    chk("in_reset_swap", swap, 0);
    chk("in_reset_clear_start", clear_start, 0);
    rstn = 1'b1;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_ready", frame_start_ready, 1);
    chk("rst_clear_start", clear_start, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_tri_count", tri_count, 0);
    chk("narrow_rst_busy", busy_n, 0);
    chk("narrow_rst_ready", frame_start_ready_n, 1);
    tri_s_valid = 1'b1; tri_m_ready = 1'b1; #1;
    chk("idle_tri_m_valid", tri_m_valid, 0);
    chk("idle_tri_s_ready", tri_s_ready, 0);
    chk("narrow_idle_tri_m_valid", tri_m_valid_n, 0);
    chk("narrow_idle_tri_s_ready", tri_s_ready_n, 0);
    tri_s_valid = 1'b0;

    // Nominal frame, vblank high
    start_frame();
    repeat (8) tick();
    clear_pulse();
    tri_s_valid = 1'b1; tri_m_ready = 1'b0; #1;
    chk("render_m_valid", tri_m_valid, 1);
    chk("render_s_ready_blocked", tri_s_ready, 0);
    tri_s_valid = 1'b0;
    send_tri(1'b0);
    send_tri(1'b0);
    send_tri(1'b1);
    chk("nom_tri_count", tri_count, 3);
    repeat (19) tick();
    sbq.push_back('{tc: 3, err: 1'b0, fc: 0, cyc: cyc + 2});
    px_pulse();
    wait_swap(20);
    chk("nom_frame_count", frame_count, 1);
    chk("nom_clear_pulses", n_clr, 1);

    // Backpressure: ready toggles, marker arrives during RENDER
    start_frame();
    clear_pulse();
    n = 0; px_sent = 1'b0;
    tri_s_valid = 1'b1;
    for (int i = 0; i < 40 && n < 5; i++) begin
      tri_m_ready = (i % 2 == 0);
      tri_s_last  = (n == 4);
      if (!px_sent && n == 2) begin
        px_valid = 1'b1; px_ready = 1'b1; px_last = 1'b1; px_sent = 1'b1;
      end
      #1;
      chk("bp_m_valid", tri_m_valid, 1);
      chk("bp_s_ready", tri_s_ready, tri_m_ready);
      if (tri_s_ready === 1'b1) n++;
      if (n == 5) sbq.push_back('{tc: 5, err: 1'b0, fc: 1, cyc: cyc + 3});
      tick();
      px_valid = 1'b0; px_ready = 1'b0; px_last = 1'b0;
    end
    tri_m_ready = 1'b1; #1;
    chk("bp_gate_m_valid", tri_m_valid, 0);
    chk("bp_gate_s_ready", tri_s_ready, 0);
    chk("bp_tri_count", tri_count, 5);
    tri_s_valid = 1'b0; tri_s_last = 1'b0;
    wait_swap(20);

    // vblank low at DRAIN exit
    vblank = 1'b0;
    start_frame();
    clear_pulse();
    send_tri(1'b1);
    px_pulse();
    for (int i = 0; i < 100; i++) begin
      chk("vbl_busy", busy, 1);
      chk("vbl_no_swap", swap, 0);
      tick();
    end
    vblank = 1'b1;
    sbq.push_back('{tc: 1, err: 1'b0, fc: 2, cyc: cyc + 1});
    wait_swap(10);

    // Lost marker; an IDLE-time marker must be ignored
    px_pulse();
    start_frame();
    clear_pulse();
    send_tri(1'b1);
    repeat (63) tick();
    chk("to_err_before", err_timeout, 0);
    chk("to_busy", busy, 1);
    sbq.push_back('{tc: 1, err: 1'b1, fc: 3, cyc: cyc + 2});
    tick();
    chk("to_err_set", err_timeout, 1);
    wait_swap(10);

    // Back-to-back minimum frames with frame_start_valid held high
    frame_start_valid = 1'b1;
    tri_s_valid = 1'b1; tri_s_last = 1'b1; tri_m_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      chk("b2b_idle_ready", frame_start_ready, 1);
      chk("b2b_idle_busy", busy, 0);
      chk("b2b_err_sticky", err_timeout, 1);
      tick();
      chk("b2b_clear_ready", frame_start_ready, 0);
      chk("b2b_clear_start", clear_start, 1);
      chk("b2b_clear_gate", tri_m_valid, 0);
      clear_done = 1'b1;
      tick();
      clear_done = 1'b0;
      chk("b2b_render_m_valid", tri_m_valid, 1);
      chk("b2b_render_s_ready", tri_s_ready, 1);
      px_valid = 1'b1; px_ready = 1'b1; px_last = 1'b1;
      sbq.push_back('{tc: 1, err: 1'b1, fc: 4 + f, cyc: cyc + 3});
      tick();
      px_valid = 1'b0; px_ready = 1'b0; px_last = 1'b0;
      chk("b2b_drain_ready", frame_start_ready, 0);
      chk("b2b_drain_gate", tri_m_valid, 0);
      tick();
      chk("b2b_wait_ready", frame_start_ready, 0);
      tick();
      chk("b2b_swap", swap, 1);
      chk("b2b_swap_ready", frame_start_ready, 0);
      tick();
    end
    frame_start_valid = 1'b0;
    tri_s_valid = 1'b0; tri_s_last = 1'b0;
    tick();
    chk("b2b_frame_count", frame_count, 8);

    // Reset mid-RENDER
    start_frame();
    clear_pulse();
    send_tri(1'b0);
    send_tri(1'b0);
    chk("pre_reset_tri_count", tri_count, 2);
    tri_s_valid = 1'b1; tri_m_ready = 1'b1;
    rstn = 1'b0;
    tick();
    chk("rr_busy", busy, 0);
    chk("rr_gate_m_valid", tri_m_valid, 0);
    chk("rr_gate_s_ready", tri_s_ready, 0);
    chk("rr_tri_count", tri_count, 0);
    chk("rr_frame_count", frame_count, 0);
    chk("rr_err", err_timeout, 0);
    chk("rr_swap", swap, 0);
    tick();
    rstn = 1'b1; tri_s_valid = 1'b0;
    tick();
    start_frame();
    clear_pulse();
    send_tri(1'b1);
    sbq.push_back('{tc: 1, err: 1'b0, fc: 0, cyc: cyc + 2});
    px_pulse();
    wait_swap(10);
    tick();
    chk("final_frame_count", frame_count, 1);
    chk("clear_start_pulses", n_clr, 10);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_scheduler.md
# frame_scheduler

Frame-level sequencer between the pipeline head and the rest of the pipeline. Accepts a frame-start request, orders a framebuffer clear, gates the triangle stream into pipeline math until the frame's last triangle, and waits for the frame-end marker at the math/tail boundary. It then issues a buffer swap aligned to vertical blanking. Runs entirely in the system clock domain.

## Interface
Parameters:
- DRAIN_TIMEOUT, 1048576: cycles allowed in DRAIN before forced exit.
- CNT_W, 16: width of frame_count and tri_count.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rstn  in  1  reset, synchronous, active-low.
- frame_start_valid  in  1  head requests a new frame.
- frame_start_ready  out  1  high only in IDLE.
- tri_s_valid  in  1  triangle valid from head.
- tri_s_ready  out  1  to head: tri_m_ready AND gate.
- tri_s_last  in  1  last triangle of frame; qualified by the tri_s handshake.
- tri_m_valid  out  1  to math: tri_s_valid AND gate.
- tri_m_ready  in  1  from math.
- px_valid  in  1  monitored math→tail valid.
- px_ready  in  1  monitored math→tail ready.
- px_last  in  1  frame-end marker. Math emits exactly one px handshake with px_last=1 per tri_s_last, possibly as a dummy pixel.
- clear_start  out  1  one-cycle pulse to tail: clear back buffer.
- clear_done  in  1  one-cycle pulse from tail: clear finished.
- vblank  in  1  level, already synchronised into clk.
- swap  out  1  one-cycle pulse: swap front/back buffers.
- frame_done  out  1  one-cycle pulse, coincident with swap.
- busy  out  1  high in every state except IDLE.
- frame_count  out  CNT_W  completed frames; wraps.
- tri_count  out  CNT_W  triangles accepted in the current/last frame; saturates at all-ones.
- err_timeout  out  1  sticky, set on DRAIN timeout.

## Operation
- States: IDLE → CLEAR → RENDER → DRAIN → WAIT_VBL → SWAP → IDLE.
- IDLE: frame_start_ready=1. On a frame_start handshake: go to CLEAR, clear tri_count, clear the px_last_seen flag.
- CLEAR: clear_start is high on the first CLEAR cycle only (registered). Stay until clear_done=1, then go to RENDER. A clear_done arriving in any other state is ignored.
- RENDER: gate=1. Each tri handshake (tri_s_valid & tri_m_ready) increments tri_count, which saturates. A handshake with tri_s_last=1 goes to DRAIN.
- gate is decoded combinationally from state (gate=1 only in RENDER). The tri_s_last handshake completes, and gate=0 from the next cycle.
- px_last_seen is set by a px handshake (px_valid & px_ready & px_last) in RENDER or DRAIN.
- DRAIN: go to WAIT_VBL when px_last_seen=1 or when a px_last handshake occurs in the current cycle. The timeout counter is reset on DRAIN entry. On reaching DRAIN_TIMEOUT-1 without a marker: set err_timeout and go to WAIT_VBL.
- WAIT_VBL: go to SWAP on the first cycle with vblank=1. This includes the entry cycle if vblank is already high.
- SWAP: swap=1 and frame_done=1 for this single cycle. frame_count increments, wrapping at 2^CNT_W. Return to IDLE.
- err_timeout clears only on reset.
- px_* handshakes seen in IDLE, CLEAR, WAIT_VBL or SWAP are ignored.

## Timing
- Reset values: state=IDLE. busy, clear_start, swap, frame_done and err_timeout are 0. frame_count and tri_count are 0. frame_start_ready=1 from the first post-reset cycle.
- Reset asserted mid-frame returns to IDLE on the next edge. No swap or clear_start pulse is emitted during reset.
- frame_start handshake at cycle t: state=CLEAR and clear_start=1 at t+1.
- clear_done at cycle t: state=RENDER at t+1, gate open.
- tri_s/tri_m are combinational pass-throughs with zero added latency. With gate=0: tri_s_ready=0 and tri_m_valid=0 regardless of the other inputs.
- DRAIN to SWAP takes at least 2 cycles (DRAIN → WAIT_VBL → SWAP).
- Minimum frame is 6 cycles, from start handshake to swap.

## Test plan
- Nominal frame, vblank held high: start, clear_done after 10 cycles, 3 triangles with the last flagged, px_last 20 cycles later. Expect one clear_start, tri_count=3, swap 2 cycles after px_last, frame_count=1.
- Backpressure: tri_m_ready toggling 50%, 5 triangles. Expect tri_count=5 and no tri_m_valid after the tri_s_last handshake while tri_s_valid is held high.
- vblank low at DRAIN exit, rising 100 cycles later. Expect swap exactly 1 cycle after vblank rises and busy high throughout.
- Lost marker with DRAIN_TIMEOUT=64 and no px_last. Expect err_timeout=1 64 cycles after DRAIN entry, swap still issued, err_timeout sticky into the next frame.
- frame_start_valid held high continuously. Expect frame_start_ready only in IDLE, back-to-back frames, and frame_count wrapping 0xFFFF→0 (preload via 65536 frames or force).
- Reset mid-RENDER. Expect IDLE with gate closed next cycle, tri_count=0, no swap; the next frame runs normally.
